video_pattern_gen: RTL
======================

VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- H_POL, 0, hsync active level
- V_POL, 0, vsync active level
- COLOR_BITS, 8, bits per colour channel; legal range 8..12

REQ-002 SHALL have these ports (name, direction, width, meaning):
- pixclk, in, 1, pixel clock; sole clock
- resetn, in, 1, asynchronous active-low reset
- mode, in, 3, requested pattern select
- solid_rgb, in, 3*COLOR_BITS, {r,g,b} for solid modes
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- blank, out, 1, inverse of de
- de, out, 1, data enable
- red, out, COLOR_BITS, red channel
- green, out, COLOR_BITS, green channel
- blue, out, COLOR_BITS, blue channel
- x, out, 12, column of current output pixel
- y, out, 12, line of current output pixel
- frame_start, out, 1, one-cycle pulse at pixel (0,0)
- frame_cnt, out, 8, completed-frame counter

Function
REQ-003 SHALL define H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; hx counts 0..H_TOTAL-1, wrap to 0; vy increments when hx wraps, wraps V_TOTAL-1 -> 0.
REQ-004 SHALL register every output; outputs at cycle n+1 reflect counter state (hx,vy) of cycle n (latency 1, all outputs mutually aligned).
REQ-005 SHALL drive hsync=H_POL when H_ACTIVE+H_FP <= hx < H_ACTIVE+H_FP+H_SYNC, else ~H_POL; vsync likewise on vy with V_* and V_POL.
REQ-006 SHALL drive de=1 iff hx<H_ACTIVE and vy<V_ACTIVE; blank=~de; red/green/blue SHALL be 0 whenever de=0.
REQ-007 SHALL output x=hx, y=vy (zero-extended) and frame_start=1 exactly when (hx,vy)=(0,0).
REQ-008 SHALL increment frame_cnt (mod 256) on the counter wrap (H_TOTAL-1,V_TOTAL-1) -> (0,0).
REQ-009 SHALL latch mode into an active-mode register only on that same wrap; a mode change mid-frame takes effect from the next frame_start and never mid-frame.
REQ-010 SHALL compute patterns as 8-bit values placed in channel MSBs with lower COLOR_BITS-8 bits zero (F = all ones):
- mode 0, colour bars: k=min(hx/(H_ACTIVE/8),7); r=~k[1], g=~k[2], b=~k[0], each expanded to F.
- mode 1, checkerboard: all channels F when hx[5]^vy[5], else 0.
- mode 2, gradient: r=hx[7:0], g=vy[7:0], b=frame_cnt.
- mode 3, diagonal: W=F if hx[7:0]==vy[7:0]; A=F if hx[7:5]==2 and vy[7:5]==2.
  - r=({hx[5:0] masked by vy[4:3]==~hx[4:3]},2'b00 | W) & ~A
  - g=(hx[7:0] masked by vy[6] | W) & ~A
  - b=vy[7:0] | W | A
- modes 4-7, solid: channels = solid_rgb at full COLOR_BITS, sampled every cycle.
REQ-011 SHALL require H_ACTIVE>=8; integer division truncates; the clamp keeps bar index <=7.

Reset
REQ-012 SHALL, while resetn=0, asynchronously force: hx=vy=0, active mode=0, frame_cnt=0, hsync=~H_POL, vsync=~V_POL, de=0, blank=1, rgb=0, x=y=0, frame_start=0.
REQ-013 SHALL, on the first pixclk edge after resetn rises, present pixel (0,0) with frame_start=1; reset mid-frame restarts timing from (0,0).

Verification (defaults; H_TOTAL=800, V_TOTAL=525)
REQ-014 Release reset, run 3 frames -> frame_start period 420000 cycles; hsync low for 96 cycles per line starting at x=656; vsync low for lines 490-491; de high 640x480 per frame.
REQ-015 Mode 0 -> rgb (FF,FF,FF) at x=0, (FF,FF,00) at x=80, (00,00,00) at x=639; at x=640 de=0, rgb=0.
REQ-016 Mode 0 -> 1 at y=100 -> colour bars to end of frame; checkerboard from next frame_start; x=32,y=0 -> all FF.
REQ-017 Mode 3, pixel (64,64) -> (00,00,FF); pixel (10,10) -> (FF,FF,FF).
REQ-018 Mode 2 for 257 frames -> frame_cnt wraps 255 -> 0 -> 1; blue at x=0 equals frame_cnt.
REQ-019 Assert resetn=0 at y=300 -> outputs reach reset values without a clock edge; after release, frame_start on first edge, frame_cnt=0, mode re-latched at next wrap.

Source files
------------

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: raster timing generator with selectable test patterns.
// Every output is registered one cycle behind the (hx, vy) raster counters.
module video_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int H_POL      = 0,
    parameter int V_POL      = 0,
    parameter int COLOR_BITS = 8
) (
    input  logic                    pixclk,
    input  logic                    resetn,
    input  logic [2:0]              mode,
    input  logic [3*COLOR_BITS-1:0] solid_rgb,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    blank,
    output logic                    de,
    output logic [COLOR_BITS-1:0]   red,
    output logic [COLOR_BITS-1:0]   green,
    output logic [COLOR_BITS-1:0]   blue,
    output logic [11:0]             x,
    output logic [11:0]             y,
    output logic                    frame_start,
    output logic [7:0]              frame_cnt
);
    localparam int CB = COLOR_BITS;
    localparam logic [11:0] HA    = 12'(H_ACTIVE);
    localparam logic [11:0] HS0   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS1   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] HT1   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] VA    = 12'(V_ACTIVE);
    localparam logic [11:0] VS0   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS1   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] VT1   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] BAR_W = 12'(H_ACTIVE / 8);
    localparam logic        HP    = (H_POL != 0);
    localparam logic        VP    = (V_POL != 0);

    logic [11:0]   r_hx, r_vy;
    logic [2:0]    r_mode;
    logic [7:0]    r_fcnt;
    logic          w_hwrap, w_vwrap, w_de, w_chk, w_w, w_a;
    logic [11:0]   w_bar;
    logic [2:0]    w_k;
    logic [7:0]    w_dr, w_dg, w_r8, w_g8, w_b8;
    logic [CB-1:0] w_rp, w_gp, w_bp, w_r, w_g, w_b;

    always_comb begin
        w_hwrap = (r_hx == HT1);
        w_vwrap = (r_vy == VT1);
        w_de    = (r_hx < HA) && (r_vy < VA);
        w_bar   = r_hx / BAR_W;
        w_k     = (w_bar > 12'd7) ? 3'd7 : w_bar[2:0];
        w_chk   = r_hx[5] ^ r_vy[5];
        w_w     = (r_hx[7:0] == r_vy[7:0]);
        w_a     = (r_hx[7:5] == 3'd2) && (r_vy[7:5] == 3'd2);
        w_dr    = {r_hx[5:0] & {6{r_vy[4:3] == ~r_hx[4:3]}}, 2'b00};
        w_dg    = r_hx[7:0] & {8{r_vy[6]}};
        w_r8    = (r_mode[1:0] == 2'd0) ? {8{~w_k[1]}} :
                  (r_mode[1:0] == 2'd1) ? {8{w_chk}} :
                  (r_mode[1:0] == 2'd2) ? r_hx[7:0] : (w_dr | {8{w_w}}) & ~{8{w_a}};
        w_g8    = (r_mode[1:0] == 2'd0) ? {8{~w_k[2]}} :
                  (r_mode[1:0] == 2'd1) ? {8{w_chk}} :
                  (r_mode[1:0] == 2'd2) ? r_vy[7:0] : (w_dg | {8{w_w}}) & ~{8{w_a}};
        w_b8    = (r_mode[1:0] == 2'd0) ? {8{~w_k[0]}} :
                  (r_mode[1:0] == 2'd1) ? {8{w_chk}} :
                  (r_mode[1:0] == 2'd2) ? r_fcnt : r_vy[7:0] | {8{w_w | w_a}};
        // 8-bit pattern values sit in the channel MSBs, low bits zero
        w_rp             = '0;
        w_gp             = '0;
        w_bp             = '0;
        w_rp[CB-1 -: 8]  = w_r8;
        w_gp[CB-1 -: 8]  = w_g8;
        w_bp[CB-1 -: 8]  = w_b8;
        w_r     = r_mode[2] ? solid_rgb[3*CB-1 -: CB] : w_rp;
        w_g     = r_mode[2] ? solid_rgb[2*CB-1 -: CB] : w_gp;
        w_b     = r_mode[2] ? solid_rgb[CB-1:0]       : w_bp;
    end

    always_ff @(posedge pixclk or negedge resetn) begin
        if (!resetn) begin
            r_hx        <= '0;
            r_vy        <= '0;
            r_mode      <= '0;
            r_fcnt      <= '0;
            hsync       <= ~HP;
            vsync       <= ~VP;
            de          <= 1'b0;
            blank       <= 1'b1;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            r_hx <= w_hwrap ? 12'd0 : r_hx + 12'd1;
            if (w_hwrap)
                r_vy <= w_vwrap ? 12'd0 : r_vy + 12'd1;
            // the pattern only switches at the frame boundary
            if (w_hwrap && w_vwrap) begin
                r_mode <= mode;
                r_fcnt <= r_fcnt + 8'd1;
            end
            hsync       <= (r_hx >= HS0 && r_hx < HS1) ? HP : ~HP;
            vsync       <= (r_vy >= VS0 && r_vy < VS1) ? VP : ~VP;
            de          <= w_de;
            blank       <= ~w_de;
            red         <= w_de ? w_r : '0;
            green       <= w_de ? w_g : '0;
            blue        <= w_de ? w_b : '0;
            x           <= r_hx;
            y           <= r_vy;
            frame_start <= (r_hx == 12'd0) && (r_vy == 12'd0);
            frame_cnt   <= r_fcnt;
        end
    end
endmodule
